// File: rtl/pr_bridge_pkg.sv
// rtl/pr_bridge_pkg.sv - shared state encoding and default parameters for pr_bridge
package pr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam int          DEF_DEV_NUM   = 3;
  localparam logic [15:0] DEF_BASE_ADDR = 16'h7f00;
  localparam int          DEF_DEV_SPAN  = 16;
  localparam int          DEF_TIMEOUT   = 15;
  localparam int          CNT_W         = 8;

endpackage

// File: rtl/pr_irq_sync.sv
// rtl/pr_irq_sync.sv - two-flop synchroniser for asynchronous level inputs
module pr_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pr_bridge.sv
// rtl/pr_bridge.sv - CPU peripheral bridge: window decode, req/ack with timeout, IRQ fold
module pr_bridge
  import pr_bridge_pkg::*;
#(
  parameter int          DEV_NUM   = DEF_DEV_NUM,
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          DEV_SPAN  = DEF_DEV_SPAN,
  parameter int          TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pr_req,
  input  logic [29:0]                 pr_addr,
  input  logic                        pr_we,
  input  logic [3:0]                  pr_be,
  input  logic [31:0]                 pr_wdata,
  output logic [31:0]                 pr_rdata,
  output logic                        pr_ready,
  output logic                        pr_err,
  output logic [5:0]                  hw_int,
  output logic [DEV_NUM-1:0]          dev_sel,
  output logic [$clog2(DEV_SPAN)-3:0] dev_addr,
  output logic                        dev_we,
  output logic [3:0]                  dev_be,
  output logic [31:0]                 dev_wdata,
  input  logic [32*DEV_NUM-1:0]       dev_rdata,
  input  logic [DEV_NUM-1:0]          dev_ack,
  input  logic [DEV_NUM-1:0]          dev_irq
);

  localparam int          SPAN_LG   = $clog2(DEV_SPAN);
  localparam logic [16:0] WIN_BYTES = 17'(DEV_NUM * DEV_SPAN);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        byte_addr;
  logic [15:0]        off;
  logic               hit;
  logic [DEV_NUM-1:0] sel_dec;
  logic [31:0]        rdata_mux;
  logic               ack_hit;
  logic [DEV_NUM-1:0] irq_q;

  assign byte_addr = {pr_addr[13:0], 2'b00};
  assign off       = byte_addr - BASE_ADDR;
  assign hit       = (pr_addr[29:14] == '0) && (byte_addr >= BASE_ADDR) &&
                     ({1'b0, off} < WIN_BYTES);

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      sel_dec[i] = (int'(32'(off) >> SPAN_LG) == i);
    end
  end

  // dev_sel is one-hot, so it doubles as the read-data mux select and ack mask
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      if (dev_sel[i]) rdata_mux = dev_rdata[i*32 +: 32];
    end
  end

  assign ack_hit = |(dev_ack & dev_sel);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dev_sel   <= '0;
      dev_addr  <= '0;
      dev_we    <= 1'b0;
      dev_be    <= '0;
      dev_wdata <= '0;
      pr_rdata  <= '0;
      pr_ready  <= 1'b0;
      pr_err    <= 1'b0;
    end else begin
      pr_ready <= 1'b0;
      pr_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pr_req && hit) begin
            dev_sel   <= sel_dec;
            dev_addr  <= byte_addr[SPAN_LG-1:2];
            dev_we    <= pr_we;
            dev_be    <= pr_be;
            dev_wdata <= pr_wdata;
            cnt       <= '0;
            state     <= ST_ACCESS;
          end else if (pr_req) begin
            pr_ready <= 1'b1;
            pr_err   <= 1'b1;
            pr_rdata <= '0;
            state    <= ST_ERR;
          end
        end
        ST_ACCESS: begin
          // an ack in the final allowed cycle still wins over the timeout
          if (ack_hit) begin
            pr_rdata <= dev_we ? 32'd0 : rdata_mux;
            dev_sel  <= '0;
            pr_ready <= 1'b1;
            state    <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            dev_sel  <= '0;
            pr_ready <= 1'b1;
            pr_err   <= 1'b1;
            pr_rdata <= '0;
            state    <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  pr_irq_sync #(.WIDTH(DEV_NUM)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (dev_irq),
    .q   (irq_q)
  );

  always_comb begin
    hw_int              = '0;
    hw_int[DEV_NUM-1:0] = irq_q;
  end

endmodule

// File: tb/tb_pr_bridge.sv
// tb/tb_pr_bridge.sv - scoreboard bench for pr_bridge with random traffic and a device model
module tb_pr_bridge;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pr_req = 1'b0;
  logic [29:0] pr_addr = '0;
  logic        pr_we = 1'b0;
  logic [3:0]  pr_be = '0;
  logic [31:0] pr_wdata = '0;
  logic [31:0] pr_rdata;
  logic        pr_ready;
  logic        pr_err;
  logic [5:0]  hw_int;
  logic [2:0]  dev_sel;
  logic [1:0]  dev_addr;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_wdata;
  logic [95:0] dev_rdata = '0;
  logic [2:0]  dev_ack = '0;
  logic [2:0]  dev_irq = '0;

  pr_bridge dut (
    .clk(clk), .rst(rst), .pr_req(pr_req), .pr_addr(pr_addr), .pr_we(pr_we),
    .pr_be(pr_be), .pr_wdata(pr_wdata), .pr_rdata(pr_rdata), .pr_ready(pr_ready),
    .pr_err(pr_err), .hw_int(hw_int), .dev_sel(dev_sel), .dev_addr(dev_addr),
    .dev_we(dev_we), .dev_be(dev_be), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
    .dev_ack(dev_ack), .dev_irq(dev_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          t0;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dexp_t;

  exp_t        sb_q[$];
  dexp_t       dv_q[$];
  logic [31:0] ref_mem [3][4];
  logic [31:0] dev_mem [3][4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          cur_delay = 0;
  int          sel_cnt = 0;
  logic [2:0]  cur_sel = '0;
  bit          irq_rand_en = 1'b0;
  logic [2:0]  h1 = '0, h2 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("err_without_ready", {63'd0, pr_err & ~pr_ready}, 64'd0);
      if (pr_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("pr_err", {63'd0, pr_err}, {63'd0, e.err});
          check("pr_rdata", {32'd0, pr_rdata}, {32'd0, e.rdata});
          check("latency", 64'(cyc - e.t0), 64'(e.lat));
        end
      end
    end
  end

  // hw_int is dev_irq as seen two rising edges earlier, cleared by reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1 = '0;
      h2 = '0;
    end else begin
      h2 = h1;
      h1 = dev_irq;
    end
  end

  always @(negedge clk) check("hw_int", {58'd0, hw_int}, {61'd0, h2});

  // device model: acks the selected slot after cur_delay select cycles, plus stray acks elsewhere
  always @(negedge clk) begin
    logic [2:0] ack;
    dexp_t d;
    ack = 3'($urandom) & 3'($urandom);
    if (!rst || dev_sel == 3'd0) begin
      sel_cnt = 0;
      dev_ack = rst ? ack : 3'd0;
    end else begin
      sel_cnt++;
      if (sel_cnt == 1) begin
        if (dv_q.size() == 0) begin
          check("unexpected_dev_sel", {61'd0, dev_sel}, 64'd0);
          cur_sel = dev_sel;
        end else begin
          d = dv_q.pop_front();
          cur_sel = d.sel;
          check("dev_sel", {61'd0, dev_sel}, {61'd0, d.sel});
          check("dev_addr", {62'd0, dev_addr}, {62'd0, d.addr});
          check("dev_we", {63'd0, dev_we}, {63'd0, d.we});
          check("dev_be", {60'd0, dev_be}, {60'd0, d.be});
          check("dev_wdata", {32'd0, dev_wdata}, {32'd0, d.wdata});
        end
      end else begin
        check("dev_sel_hold", {61'd0, dev_sel}, {61'd0, cur_sel});
      end
      ack = ack & ~dev_sel;
      if (sel_cnt == cur_delay) begin
        ack = ack | dev_sel;
        if (dev_we) begin
          for (int i = 0; i < 3; i++) begin
            if (dev_sel[i]) begin
              for (int b = 0; b < 4; b++) begin
                if (dev_be[b]) dev_mem[i][dev_addr][8*b +: 8] = dev_wdata[8*b +: 8];
              end
            end
          end
        end
      end
      dev_ack = ack;
    end
    for (int i = 0; i < 3; i++) dev_rdata[i*32 +: 32] = dev_mem[i][dev_addr];
  end

  initial begin
    while (1) begin
      @(negedge clk);
      #2;
      if (irq_rand_en && $urandom_range(0, 7) == 0) dev_irq = 3'($urandom);
    end
  end

  // issue one access from an IDLE negedge; returns at the next IDLE negedge
  task automatic do_xfer(input logic [31:0] baddr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input int delay, input bit drop);
    exp_t  e;
    dexp_t d;
    int    s, w, n;
    bit    mapped;
    logic [15:0] lo;
    lo = baddr[15:0];
    mapped = (baddr[31:16] == 16'd0) && (lo >= 16'h7f00) && (lo < 16'h7f30);
    e.t0 = cyc;
    if (!mapped) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1;
    end else begin
      s = (int'(lo) - 'h7f00) / 16;
      w = ((int'(lo) - 'h7f00) % 16) / 4;
      d.sel = 3'(1 << s); d.addr = 2'(w); d.we = we; d.be = be; d.wdata = wdata;
      dv_q.push_back(d);
      if (delay > TIMEOUT) begin
        e.err = 1'b1; e.rdata = '0; e.lat = TIMEOUT + 1;
      end else begin
        e.err = 1'b0; e.lat = delay + 1;
        e.rdata = we ? 32'd0 : ref_mem[s][w];
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[s][w][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end
    sb_q.push_back(e);
    cur_delay = delay;
    pr_req = 1'b1; pr_addr = baddr[31:2]; pr_we = we; pr_be = be; pr_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop) pr_req = 1'b0;
    end while (!pr_ready && n < 60);
    if (!pr_ready) check("ready_bound", 64'd0, 64'd1);
    pr_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r, s, w, dly;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        ref_mem[i][j] = $urandom;
        dev_mem[i][j] = ref_mem[i][j];
      end
    end
    repeat (2) @(negedge clk);
    check("reset_ready", {63'd0, pr_ready}, 64'd0);
    check("reset_sel", {61'd0, dev_sel}, 64'd0);
    check("reset_rdata", {32'd0, pr_rdata}, 64'd0);
    #2 rst = 1'b1;
    @(negedge clk);

    do_xfer(32'h0000_7f04, 1'b1, 4'hf, 32'h0000_00ff, 2, 1'b0);
    ref_mem[1][1] = 32'hdeadbeef;
    dev_mem[1][1] = 32'hdeadbeef;
    do_xfer(32'h0000_7f14, 1'b0, 4'hf, 32'h0, 1, 1'b0);
    do_xfer(32'h0000_7f40, 1'b0, 4'hf, 32'h0, 1, 1'b0);
    do_xfer(32'h0001_7f00, 1'b0, 4'hf, 32'h0, 1, 1'b0);
    do_xfer(32'h0000_7f24, 1'b0, 4'hf, 32'h0, 99, 1'b0);
    do_xfer(32'h0000_7f28, 1'b0, 4'hf, 32'h0, TIMEOUT, 1'b0);
    do_xfer(32'h0000_7f04, 1'b0, 4'hf, 32'h0, 3, 1'b1);

    #2 dev_irq = 3'b101;
    @(negedge clk);
    check("irq_one_edge", {58'd0, hw_int}, 64'd0);
    @(negedge clk);
    check("irq_set", {58'd0, hw_int}, 64'h5);
    #2 dev_irq = 3'b000;
    repeat (2) @(negedge clk);
    check("irq_clear", {58'd0, hw_int}, 64'd0);

    irq_rand_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 2);
      w = $urandom_range(0, 3);
      a = 32'h7f00 + 32'(s * 16 + w * 4);
      dly = $urandom_range(1, 4);
      if (r < 4) a = 32'h7f30 + 32'($urandom_range(0, 63) * 4);
      else if (r < 8) a = 32'h0001_0000 | a | (32'($urandom_range(1, 255)) << 16);
      else if (r < 12) a = 32'h7e00 + 32'($urandom_range(0, 63) * 4);
      else if (r < 20) dly = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
      else if (r < 24) dly = TIMEOUT;
      do_xfer(a, 1'($urandom), 4'($urandom), $urandom, dly, $urandom_range(0, 7) == 0);
    end
    irq_rand_en = 1'b0;

    #2 dev_irq = 3'b011;
    repeat (3) @(negedge clk);
    pr_req = 1'b1; pr_addr = 30'(32'h7f08 >> 2); pr_we = 1'b0; pr_be = 4'hf;
    dv_q.push_back('{sel: 3'b001, addr: 2'd2, we: 1'b0, be: 4'hf, wdata: pr_wdata});
    cur_delay = 99;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_dev_sel", {61'd0, dev_sel}, 64'd0);
    check("rst_pr_ready", {63'd0, pr_ready}, 64'd0);
    check("rst_hw_int", {58'd0, hw_int}, 64'd0);
    pr_req = 1'b0;
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    do_xfer(32'h0000_7f18, 1'b0, 4'hf, 32'h0, 2, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("dev_q_drained", 64'(dv_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
